// File: rtl/flex_bus_pkg.sv
// Shared flex bus types: responder handshake states, default bus widths and
// the address window test used by slave-side decoders.
package flex_bus_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} resp_state_t;

  localparam int unsigned BB_ADDR_W = 16;
  localparam int unsigned BB_DATA_W = 16;

  // The upper bound is computed one bit wider so a window touching the top of
  // the address space cannot wrap back to zero.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] count);
    logic [32:0] limit;
    limit = {1'b0, base} + {1'b0, count};
    return (addr >= base) && ({1'b0, addr} < limit);
  endfunction

endpackage

// File: rtl/flex_resp_fsm.sv
// Responder handshake: window decode, index/direction/data latch, wait-state
// counter, dtack and read ownership flag.
module flex_resp_fsm
  import flex_bus_pkg::*;
#(
  parameter int unsigned addr_bus_width = BB_ADDR_W,
  parameter int unsigned data_bus_width = BB_DATA_W,
  parameter int unsigned base_addr      = 0,
  parameter int unsigned reg_count      = 8,
  parameter int unsigned wait_states    = 1,
  parameter int unsigned idx_w          = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [addr_bus_width-1:0] addr,
  input  logic                      addr_strobe,
  input  logic                      rd_active,
  input  logic                      wr_active,
  input  logic [data_bus_width-1:0] data_in,
  output logic [idx_w-1:0]          idx,
  output logic [data_bus_width-1:0] wdata,
  output logic                      dtack,
  output logic                      reg_rd_active,
  output logic                      wr_fire,
  output logic                      rd_fire
);

  resp_state_t state;
  logic [3:0]  cnt;
  logic        is_wr;
  logic        entry;
  logic        hit;
  logic        dir_active;

  assign hit        = addr_strobe && in_window(32'(addr), base_addr, reg_count);
  assign dir_active = is_wr ? wr_active : rd_active;

  // Commit happens on the first ACK edge, and only if the master is still there.
  assign wr_fire = (state == ACK) && entry && dir_active && is_wr;
  assign rd_fire = (state == ACK) && entry && dir_active && !is_wr;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      is_wr         <= 1'b0;
      entry         <= 1'b0;
      idx           <= '0;
      wdata         <= '0;
      dtack         <= 1'b0;
      reg_rd_active <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dtack         <= 1'b0;
          reg_rd_active <= 1'b0;
          if (hit && (rd_active ^ wr_active)) begin
            idx   <= idx_w'(addr - addr_bus_width'(base_addr));
            is_wr <= wr_active;
            wdata <= data_in;
            cnt   <= 4'(wait_states);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!dir_active) begin
            state <= IDLE;
          end else if (cnt == 4'd0) begin
            state <= ACK;
            entry <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACK: begin
          entry <= 1'b0;
          if (!dir_active) begin
            state         <= IDLE;
            dtack         <= 1'b0;
            reg_rd_active <= 1'b0;
          end else begin
            dtack <= 1'b1;
            if (entry && !is_wr) reg_rd_active <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/flex_reg_responder.sv
// Flex bus slave responder: register bank with per-register write strobes and
// optional external readback, driven by the flex_resp_fsm handshake.
module flex_reg_responder
  import flex_bus_pkg::*;
#(
  parameter int unsigned         addr_bus_width = BB_ADDR_W,
  parameter int unsigned         data_bus_width = BB_DATA_W,
  parameter int unsigned         base_addr      = 0,
  parameter int unsigned         reg_count      = 8,
  parameter int unsigned         wait_states    = 1,
  parameter logic [31:0]         readback_mask  = '0,
  parameter logic [data_bus_width-1:0] reset_value = '0
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [addr_bus_width-1:0]           addr,
  input  logic                                addr_strobe,
  input  logic                                rd_active,
  input  logic                                wr_active,
  input  logic [data_bus_width-1:0]           data_in,
  output logic [data_bus_width-1:0]           data_out,
  output logic                                reg_rd_active,
  output logic                                dtack,
  output logic [reg_count*data_bus_width-1:0] reg_out,
  input  logic [reg_count*data_bus_width-1:0] reg_in,
  output logic [reg_count-1:0]                wr_pulse
);

  localparam int unsigned idx_w = (reg_count > 1) ? $clog2(reg_count) : 1;

  logic [data_bus_width-1:0] regs [reg_count];
  logic [idx_w-1:0]          idx;
  logic [data_bus_width-1:0] wdata;
  logic [data_bus_width-1:0] rd_src;
  logic                      wr_fire;
  logic                      rd_fire;

  flex_resp_fsm #(
    .addr_bus_width (addr_bus_width),
    .data_bus_width (data_bus_width),
    .base_addr      (base_addr),
    .reg_count      (reg_count),
    .wait_states    (wait_states),
    .idx_w          (idx_w)
  ) u_fsm (
    .clock         (clock),
    .reset         (reset),
    .addr          (addr),
    .addr_strobe   (addr_strobe),
    .rd_active     (rd_active),
    .wr_active     (wr_active),
    .data_in       (data_in),
    .idx           (idx),
    .wdata         (wdata),
    .dtack         (dtack),
    .reg_rd_active (reg_rd_active),
    .wr_fire       (wr_fire),
    .rd_fire       (rd_fire)
  );

  always_comb begin
    rd_src = regs[idx];
    if (readback_mask[idx]) rd_src = reg_in[int'(idx)*data_bus_width +: data_bus_width];
  end

  for (genvar i = 0; i < reg_count; i++) begin : g_out
    assign reg_out[i*data_bus_width +: data_bus_width] = regs[i];
  end

  // Read data is captured once and held; it is forced to zero whenever the
  // responder does not own the bus so hub outputs can simply be OR-ed.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < reg_count; i++) regs[i] <= reset_value;
      wr_pulse <= '0;
      data_out <= '0;
    end else begin
      wr_pulse <= '0;
      if (wr_fire) begin
        regs[idx]     <= wdata;
        wr_pulse[idx] <= 1'b1;
      end
      if (rd_fire) data_out <= rd_src;
      else if (!(reg_rd_active && rd_active)) data_out <= '0;
    end
  end

endmodule

// File: tb/tb_flex_reg_responder.sv
// Bench for flex_reg_responder: three responders (0, 1 and 4 wait states)
// share one bus and are checked cycle by cycle against a transaction model.
module tb_flex_reg_responder;
  localparam int          DW      = 16;
  localparam int          AW      = 16;
  localparam int          RC      = 8;
  localparam int          BASE    = 'h0200;
  localparam logic [15:0] RST_VAL = 16'h00A5;
  localparam logic [31:0] RB_MASK = 32'h0000_0020;

  logic              clock = 1'b0;
  logic              reset;
  logic [AW-1:0]     addr;
  logic              addr_strobe;
  logic              rd_active;
  logic              wr_active;
  logic [DW-1:0]     data_in;
  logic [RC*DW-1:0]  reg_in;

  logic [DW-1:0]     dout [3];
  logic              rda  [3];
  logic              dtk  [3];
  logic [RC*DW-1:0]  rout [3];
  logic [RC-1:0]     wpl  [3];

  int                wsv [3] = '{0, 1, 4};
  logic [15:0]       mdl [3][RC];
  int                n_tests = 0;
  int                n_fail  = 0;

  always #5 clock = ~clock;

  flex_reg_responder #(.addr_bus_width(AW), .data_bus_width(DW), .base_addr(BASE),
    .reg_count(RC), .wait_states(0), .readback_mask(RB_MASK), .reset_value(RST_VAL)) dut0 (
    .clock(clock), .reset(reset), .addr(addr), .addr_strobe(addr_strobe),
    .rd_active(rd_active), .wr_active(wr_active), .data_in(data_in),
    .data_out(dout[0]), .reg_rd_active(rda[0]), .dtack(dtk[0]), .reg_out(rout[0]),
    .reg_in(reg_in), .wr_pulse(wpl[0]));

  flex_reg_responder #(.addr_bus_width(AW), .data_bus_width(DW), .base_addr(BASE),
    .reg_count(RC), .wait_states(1), .readback_mask(RB_MASK), .reset_value(RST_VAL)) dut1 (
    .clock(clock), .reset(reset), .addr(addr), .addr_strobe(addr_strobe),
    .rd_active(rd_active), .wr_active(wr_active), .data_in(data_in),
    .data_out(dout[1]), .reg_rd_active(rda[1]), .dtack(dtk[1]), .reg_out(rout[1]),
    .reg_in(reg_in), .wr_pulse(wpl[1]));

  flex_reg_responder #(.addr_bus_width(AW), .data_bus_width(DW), .base_addr(BASE),
    .reg_count(RC), .wait_states(4), .readback_mask(RB_MASK), .reset_value(RST_VAL)) dut2 (
    .clock(clock), .reset(reset), .addr(addr), .addr_strobe(addr_strobe),
    .rd_active(rd_active), .wr_active(wr_active), .data_in(data_in),
    .data_out(dout[2]), .reg_rd_active(rda[2]), .dtack(dtk[2]), .reg_out(rout[2]),
    .reg_in(reg_in), .wr_pulse(wpl[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_dtack%0d", tag, k), 32'(dtk[k]), 32'd0);
      chk($sformatf("%s_rdact%0d", tag, k), 32'(rda[k]), 32'd0);
      chk($sformatf("%s_dout%0d", tag, k), 32'(dout[k]), 32'd0);
      chk($sformatf("%s_wpulse%0d", tag, k), 32'(wpl[k]), 32'd0);
    end
  endtask

  task automatic chk_regs(input string tag);
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < RC; r++)
        chk($sformatf("%s_reg%0d_%0d", tag, k, r), 32'(rout[k][r*DW +: DW]), 32'(mdl[k][r]));
  endtask

  // Transaction model: the access is accepted iff the address is in the window
  // and exactly one direction is active. With the hit sampled at edge 0 and
  // the active line held for edges 0..h-1, a responder with W wait states
  // commits at edge W+2 if h >= W+3 and shows dtack on edges W+2..h-1.
  task automatic run_access(input string tag, input logic [15:0] a, input bit wr,
                            input bit rd, input logic [15:0] d, input int h);
    bit          resp;
    bit          on;
    int          idx;
    logic [15:0] rexp;
    resp = (int'(a) >= BASE) && (int'(a) < BASE + RC) && (wr ^ rd);
    idx  = int'(a) - BASE;
    @(negedge clock);
    addr = a; addr_strobe = 1'b1; wr_active = wr; rd_active = rd; data_in = d;
    for (int n = 0; n <= h + 1; n++) begin
      @(posedge clock); #1;
      if (n == 0) data_in = 16'($urandom);
      for (int k = 0; k < 3; k++) begin
        on   = resp && (h >= wsv[k] + 3) && (n >= wsv[k] + 2) && (n <= h - 1);
        rexp = 16'h0;
        if (on && rd) rexp = RB_MASK[idx] ? reg_in[idx*DW +: DW] : mdl[k][idx];
        chk($sformatf("%s_n%0d_dtack%0d", tag, n, k), 32'(dtk[k]), 32'(on));
        chk($sformatf("%s_n%0d_rdact%0d", tag, n, k), 32'(rda[k]), 32'(on && rd));
        chk($sformatf("%s_n%0d_dout%0d", tag, n, k), 32'(dout[k]), 32'(rexp));
        if (on && wr && n == wsv[k] + 2) begin
          chk($sformatf("%s_n%0d_wpulse%0d", tag, n, k), 32'(wpl[k]), 32'(1) << idx);
          mdl[k][idx] = d;
        end else begin
          chk($sformatf("%s_n%0d_wpulse%0d", tag, n, k), 32'(wpl[k]), 32'd0);
        end
      end
      if (n == h - 1) begin
        addr_strobe = 1'b0; rd_active = 1'b0; wr_active = 1'b0; addr = 16'($urandom);
      end
    end
    chk_regs(tag);
  endtask

  initial begin
    reset = 1'b0; addr = '0; addr_strobe = 1'b0; rd_active = 1'b0; wr_active = 1'b0;
    data_in = '0;
    for (int r = 0; r < RC; r++) reg_in[r*DW +: DW] = 16'($urandom);
    for (int k = 0; k < 3; k++) for (int r = 0; r < RC; r++) mdl[k][r] = RST_VAL;

    repeat (2) @(posedge clock);
    #1;
    chk_idle_outputs("reset");
    chk_regs("reset");
    reset = 1'b1;

    run_access("wr203", 16'h0203, 1'b1, 1'b0, 16'h1234, 8);
    run_access("rd203", 16'h0203, 1'b0, 1'b1, 16'h0000, 6);

    reg_in[5*DW +: DW] = 16'hBEEF;
    run_access("rd205", 16'h0205, 1'b0, 1'b1, 16'h0000, 7);
    run_access("wr205", 16'h0205, 1'b1, 1'b0, 16'hC0DE, 8);
    run_access("rd205b", 16'h0205, 1'b0, 1'b1, 16'h0000, 8);

    run_access("lo1ff", 16'h01FF, 1'b1, 1'b0, 16'h5555, 8);
    run_access("hi208", 16'h0208, 1'b1, 1'b0, 16'h6666, 8);
    run_access("top207", 16'h0207, 1'b1, 1'b0, 16'h7777, 8);
    run_access("rd207", 16'h0207, 1'b0, 1'b1, 16'h0000, 8);
    run_access("both", 16'h0204, 1'b1, 1'b1, 16'h8888, 8);
    run_access("abort", 16'h0202, 1'b0, 1'b1, 16'h0000, 3);
    run_access("wabort", 16'h0201, 1'b1, 1'b0, 16'h9999, 4);

    for (int t = 0; t < 24; t++) begin
      logic [15:0] a;
      int          mode;
      a    = 16'(BASE - 1 + $urandom_range(0, RC + 1));
      mode = $urandom_range(0, 5);
      if (mode == 5) reg_in[5*DW +: DW] = 16'($urandom);
      run_access($sformatf("rnd%0d", t), a, mode inside {0, 1, 4}, mode inside {2, 3, 4},
                 16'($urandom), $urandom_range(1, 9));
    end

    // Reset sampled on the ACK entry edge of the 4-wait-state responder.
    @(negedge clock);
    addr = 16'h0206; addr_strobe = 1'b1; wr_active = 1'b1; rd_active = 1'b0; data_in = 16'hDEAD;
    repeat (6) @(posedge clock);
    #1;
    reset = 1'b0; addr_strobe = 1'b0; wr_active = 1'b0;
    @(posedge clock); #1;
    for (int k = 0; k < 3; k++) for (int r = 0; r < RC; r++) mdl[k][r] = RST_VAL;
    chk_idle_outputs("midreset");
    chk_regs("midreset");
    reset = 1'b1;
    run_access("postrst", 16'h0206, 1'b0, 1'b1, 16'h0000, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
